// File: rtl/match_tracker_pipe.sv
// match_tracker_pipe: streams candidate groups against one target descriptor, tracking L1 min/min2/pos
// and emitting one ratio-tested result per target.
module match_tracker_pipe #(
  parameter int LANES     = 4,
  parameter int DIM       = 48,
  parameter int ELEM_W    = 8,
  parameter int POS_W     = 19,
  parameter int RATIO_NUM = 4,
  parameter int RATIO_DEN = 5,
  parameter int DIST_W    = ELEM_W + $clog2(DIM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tar_valid,
  output logic                         tar_ready,
  input  logic [DIM*ELEM_W-1:0]        tar_data,
  input  logic                         cand_valid,
  output logic                         cand_ready,
  input  logic [LANES*DIM*ELEM_W-1:0]  cand_data,
  input  logic [LANES*POS_W-1:0]       cand_pos,
  input  logic [LANES-1:0]             cand_mask,
  input  logic                         cand_last,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [POS_W-1:0]             res_pos,
  output logic [DIST_W-1:0]            res_min,
  output logic [DIST_W-1:0]            res_min2,
  output logic                         res_ok,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  localparam int DW = DIM * ELEM_W;
  localparam int PW = DIST_W + 8;
  localparam logic [DIST_W-1:0] DMAX = '1;
  state_t                r_state;
  logic                  r_cnt;
  logic [DW-1:0]         r_tar;
  logic                  r_s1_v, r_s2_v;
  logic [DIST_W-1:0]     r_s1_d [LANES];
  logic [POS_W-1:0]      r_s1_pos [LANES];
  logic [LANES-1:0]      r_s1_m;
  logic [DIST_W-1:0]     r_s2_gm, r_s2_gm2, r_min, r_min2;
  logic [POS_W-1:0]      r_s2_gp, r_pos;
  logic                  w_acc, w_lt, w_ok;
  logic [DIST_W-1:0]     w_dist [LANES];
  logic [POS_W-1:0]      w_pos_in [LANES];
  logic [DIST_W-1:0]     w_gm, w_gm2, w_min_n, w_min2_n;
  logic [POS_W-1:0]      w_gp, w_pos_n;
  logic [PW-1:0]         w_lhs, w_rhs;
  function automatic logic [DIST_W-1:0] l1(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DIST_W-1:0] s;
    s = '0;
    for (int i = 0; i < DIM; i++)
      s = s + DIST_W'(a[i*ELEM_W +: ELEM_W] > b[i*ELEM_W +: ELEM_W] ?
                      a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W] :
                      b[i*ELEM_W +: ELEM_W] - a[i*ELEM_W +: ELEM_W]);
    return s;
  endfunction
  assign tar_ready  = r_state == IDLE;
  assign cand_ready = r_state == RUN;
  assign busy       = r_state != IDLE;
  assign w_acc      = cand_valid && cand_ready;
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_dist[k]   = cand_mask[k] ? l1(r_tar, cand_data[k*DW +: DW]) : DMAX;
      w_pos_in[k] = cand_pos[k*POS_W +: POS_W];
    end
  end
  // Strict compares keep the lowest lane on ties; masked lanes never win.
  always_comb begin
    w_gm  = DMAX;
    w_gm2 = DMAX;
    w_gp  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (r_s1_m[k] && r_s1_d[k] < w_gm) begin
        w_gm2 = w_gm;
        w_gm  = r_s1_d[k];
        w_gp  = r_s1_pos[k];
      end else if (r_s1_m[k] && r_s1_d[k] < w_gm2) begin
        w_gm2 = r_s1_d[k];
      end
    end
  end
  // Group min2 >= group min, so it only matters when the group min displaces the running min.
  assign w_lt     = r_s2_v && r_s2_gm < r_min;
  assign w_min_n  = w_lt ? r_s2_gm : r_min;
  assign w_pos_n  = w_lt ? r_s2_gp : r_pos;
  assign w_min2_n = w_lt ? (r_s2_gm2 < r_min ? r_s2_gm2 : r_min) :
                    (r_s2_v && r_s2_gm < r_min2) ? r_s2_gm : r_min2;
  assign w_lhs    = PW'(w_min_n) * PW'(RATIO_DEN);
  assign w_rhs    = PW'(w_min2_n) * PW'(RATIO_NUM);
  assign w_ok     = w_min_n != DMAX && w_lhs < w_rhs;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 1'b0;
      r_tar     <= '0;
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_min     <= DMAX;
      r_min2    <= DMAX;
      r_pos     <= '0;
      res_valid <= 1'b0;
      res_pos   <= '0;
      res_min   <= '0;
      res_min2  <= '0;
      res_ok    <= 1'b0;
    end else begin
      r_s1_v   <= w_acc;
      r_s1_d   <= w_dist;
      r_s1_pos <= w_pos_in;
      r_s1_m   <= cand_mask;
      r_s2_v   <= r_s1_v;
      r_s2_gm  <= w_gm;
      r_s2_gm2 <= w_gm2;
      r_s2_gp  <= w_gp;
      r_min    <= w_min_n;
      r_min2   <= w_min2_n;
      r_pos    <= w_pos_n;
      case (r_state)
        IDLE: if (tar_valid) begin
          r_state <= RUN;
          r_tar   <= tar_data;
          r_min   <= DMAX;
          r_min2  <= DMAX;
          r_pos   <= '0;
        end
        RUN: if (w_acc && cand_last) begin
          r_state <= DRAIN;
          r_cnt   <= 1'b0;
        end
        DRAIN: begin
          r_cnt <= 1'b1;
          if (r_cnt) begin
            r_state   <= OUT;
            res_valid <= 1'b1;
            res_pos   <= w_pos_n;
            res_min   <= w_min_n;
            res_min2  <= w_min2_n;
            res_ok    <= w_ok;
          end
        end
        OUT: if (res_ready) begin
          r_state   <= IDLE;
          res_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_match_tracker_pipe.sv
// tb_match_tracker_pipe: directed streams checked against a whole-stream min/second-min model
// plus literal expectations per scenario.
module tb_match_tracker_pipe;
  localparam int LANES = 4, DIM = 48, ELEM_W = 8, POS_W = 19, DW = 14;
  localparam int DMAX = (1 << DW) - 1;
  localparam int TW = DIM * ELEM_W;
  logic clk = 0, rst = 1;
  logic tar_valid = 0, tar_ready;
  logic [TW-1:0] tar_data = '0;
  logic cand_valid = 0, cand_ready, cand_last = 0;
  logic [LANES*TW-1:0] cand_data = '0;
  logic [LANES*POS_W-1:0] cand_pos = '0;
  logic [LANES-1:0] cand_mask = '0;
  logic res_valid, res_ready = 1, res_ok, busy;
  logic [POS_W-1:0] res_pos;
  logic [DW-1:0] res_min, res_min2;
  int n_cmp = 0, n_err = 0;
  int exp_min, exp_min2, exp_pos, exp_ok;
  logic exp_on = 0;
  int d_q[$];
  int p_q[$];
  logic [TW-1:0] tgt;
  match_tracker_pipe dut (
    .clk(clk), .rst(rst),
    .tar_valid(tar_valid), .tar_ready(tar_ready), .tar_data(tar_data),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
    .cand_pos(cand_pos), .cand_mask(cand_mask), .cand_last(cand_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_pos(res_pos),
    .res_min(res_min), .res_min2(res_min2), .res_ok(res_ok), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  // Candidate with exact L1 distance d from an all-100 target, stepping both below and above.
  function automatic logic [TW-1:0] mk(int d);
    logic [TW-1:0] v;
    int r, x;
    r = d;
    for (int i = 0; i < DIM; i++) begin
      x = (i % 2) ? (r > 155 ? 155 : r) : (r > 100 ? 100 : r);
      v[i*ELEM_W +: ELEM_W] = (i % 2) ? 8'(100 + x) : 8'(100 - x);
      r -= x;
    end
    return v;
  endfunction
  function automatic int l1(logic [TW-1:0] a, logic [TW-1:0] b);
    int s, ea, eb;
    s = 0;
    for (int i = 0; i < DIM; i++) begin
      ea = int'(a[i*ELEM_W +: ELEM_W]);
      eb = int'(b[i*ELEM_W +: ELEM_W]);
      s += ea > eb ? ea - eb : eb - ea;
    end
    return s;
  endfunction
  // Whole-stream view: best = first occurrence of the smallest distance, second = smallest of the rest.
  task automatic model();
    int b, s, bi;
    b = DMAX; s = DMAX; bi = -1; exp_pos = 0;
    foreach (d_q[i]) if (d_q[i] < b) begin b = d_q[i]; bi = i; exp_pos = p_q[i]; end
    foreach (d_q[i]) if (i != bi && d_q[i] < s) s = d_q[i];
    exp_min = b; exp_min2 = s;
    exp_ok = (b != DMAX && b * 5 < s * 4) ? 1 : 0;
    exp_on = 1;
  endtask
  task automatic start();
    d_q.delete(); p_q.delete();
    exp_on = 0;
    chk("tar_ready", tar_ready, 1);
    tar_data = tgt; tar_valid = 1;
    @(posedge clk); #1 tar_valid = 0;
  endtask
  task automatic grp(int d0, int d1, int d2, int d3, logic [3:0] m, logic last, int base);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < LANES; k++) begin
      cand_data[k*TW +: TW] = mk(d[k]);
      cand_pos[k*POS_W +: POS_W] = POS_W'(base + k);
      if (m[k]) begin
        d_q.push_back(l1(tgt, cand_data[k*TW +: TW]));
        p_q.push_back(base + k);
      end
    end
    cand_mask = m; cand_last = last; cand_valid = 1;
    if (last) model();
    chk("cand_ready", cand_ready, 1);
    @(posedge clk); #1 cand_valid = 0; cand_last = 0;
  endtask
  task automatic wait_res(int lmin, int lmin2, int lpos, int lok);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 20);
    chk("latency", n, 3);
    chk("lit_min", res_min, lmin);
    chk("lit_min2", res_min2, lmin2);
    chk("lit_pos", res_pos, lpos);
    chk("lit_ok", res_ok, lok);
    if (res_ready) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", res_valid, 0);
      chk("idle_tar_ready", tar_ready, 1);
    end
  endtask
  always @(negedge clk) begin
    if (res_valid && exp_on) begin
      chk("res_min", res_min, exp_min);
      chk("res_min2", res_min2, exp_min2);
      chk("res_pos", res_pos, exp_pos);
      chk("res_ok", res_ok, exp_ok);
    end else if (res_valid) chk("spurious_res_valid", res_valid, 0);
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < DIM; i++) tgt[i*ELEM_W +: ELEM_W] = 8'd100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cand_ready", cand_ready, 0);
    chk("rst_res_min", res_min, 0);
    chk("rst_res_ok", res_ok, 0);
    rst = 0;
    @(negedge clk);
    start();
    grp(40, 10, 30, 20, 4'hF, 1, 'h100);
    wait_res(10, 20, 'h101, 1);
    start();
    grp(100, 150, 160, 170, 4'hF, 0, 'h200);
    grp(90, 95, 120, 130, 4'hF, 0, 'h210);
    grp(200, 200, 200, 200, 4'hF, 1, 'h220);
    wait_res(90, 95, 'h210, 0);
    start();
    grp(50, 60, 7, 7, 4'hF, 0, 'h300);
    grp(7, 40, 40, 40, 4'hF, 1, 'h310);
    wait_res(7, 7, 'h302, 0);
    start();
    grp(5, 9, 9, 9, 4'b0001, 1, 'h400);
    wait_res(5, DMAX, 'h400, 1);
    start();
    grp(1, 2, 3, 4, 4'b0000, 0, 'h410);
    grp(1, 1, 1, 1, 4'b0000, 1, 'h420);
    wait_res(DMAX, DMAX, 0, 0);
    res_ready = 0;
    start();
    grp(20, 30, 40, 50, 4'hF, 1, 'h450);
    wait_res(20, 30, 'h450, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_tar_ready", tar_ready, 0);
      chk("hold_cand_ready", cand_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    chk("release_busy", busy, 0);
    chk("release_valid", res_valid, 0);
    start();
    grp(1, 1, 1, 1, 4'hF, 0, 'h500);
    grp(2, 2, 2, 2, 4'hF, 0, 'h510);
    exp_on = 0;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cand_ready", cand_ready, 0);
    chk("midrst_res_min", res_min, 0);
    chk("midrst_res_pos", res_pos, 0);
    start();
    grp(50, 70, 80, 90, 4'hF, 1, 'h600);
    wait_res(50, 70, 'h600, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
